// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, runs the IMEM read handshake and feeds the IF/ID register.
// Define IFU_HOLD_BUFFER_EN to add the HOLD state that buffers a stalled instruction instead of re-reading it.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] OUT_INSTRUCTION,
    output logic [31:0] OUT_PC,
    output logic        BUSYWAIT
);
    localparam logic [1:0] ST_FETCH = 2'd0;
`ifdef IFU_HOLD_BUFFER_EN
    localparam logic [1:0] ST_HOLD  = 2'd1;
`endif
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] pend_target_r;
    logic [31:0] pend_target_nxt_s;
    logic [31:0] pc_inc_s;
    logic [31:0] drain_target_s;
`ifdef IFU_HOLD_BUFFER_EN
    logic [31:0] hold_instr_r;
    logic [31:0] hold_instr_nxt_s;
`endif

    assign pc_inc_s       = pc_r + 32'd4;
    assign drain_target_s = BRANCH_TAKEN ? BRANCH_TARGET : pend_target_r;
    assign IMEM_ADDRESS   = pc_r;
    assign OUT_PC         = pc_r;

    // Output decode: read request, presented instruction and the IF/ID load qualifier
    always_comb begin
        IMEM_READ       = 1'b0;
        OUT_INSTRUCTION = 32'h0000_0000;
        BUSYWAIT        = 1'b1;
        if (RESET) begin
            IMEM_READ       = 1'b0;
            OUT_INSTRUCTION = 32'h0000_0000;
            BUSYWAIT        = 1'b1;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    IMEM_READ       = 1'b1;
                    OUT_INSTRUCTION = IMEM_READDATA;
                    BUSYWAIT        = IMEM_BUSYWAIT | BRANCH_TAKEN;
                end
`ifdef IFU_HOLD_BUFFER_EN
                ST_HOLD: begin
                    IMEM_READ       = 1'b0;
                    OUT_INSTRUCTION = hold_instr_r;
                    BUSYWAIT        = BRANCH_TAKEN;
                end
`endif
                ST_DRAIN: begin
                    // Old read must complete before the redirect target is fetched
                    IMEM_READ       = 1'b1;
                    OUT_INSTRUCTION = 32'h0000_0000;
                    BUSYWAIT        = 1'b1;
                end
                default: begin
                    IMEM_READ       = 1'b0;
                    OUT_INSTRUCTION = 32'h0000_0000;
                    BUSYWAIT        = 1'b1;
                end
            endcase
        end
    end

    // Next-state logic: redirect first, then memory wait, then stall/delivery
    always_comb begin
        state_nxt_s       = state_r;
        pc_nxt_s          = pc_r;
        pend_target_nxt_s = pend_target_r;
`ifdef IFU_HOLD_BUFFER_EN
        hold_instr_nxt_s  = hold_instr_r;
`endif
        case (state_r)
            ST_FETCH: begin
                if (BRANCH_TAKEN) begin
                    if (IMEM_BUSYWAIT) begin
                        pend_target_nxt_s = BRANCH_TARGET;
                        state_nxt_s       = ST_DRAIN;
                    end else begin
                        pc_nxt_s    = BRANCH_TARGET;
                        state_nxt_s = ST_FETCH;
                    end
                end else if (IMEM_BUSYWAIT) begin
                    state_nxt_s = ST_FETCH;
                end else if (!STALL) begin
                    pc_nxt_s    = pc_inc_s;
                    state_nxt_s = ST_FETCH;
                end else begin
`ifdef IFU_HOLD_BUFFER_EN
                    hold_instr_nxt_s = IMEM_READDATA;
                    state_nxt_s      = ST_HOLD;
`else
                    // Without the buffer the same PC is simply re-read next cycle
                    state_nxt_s = ST_FETCH;
`endif
                end
            end
`ifdef IFU_HOLD_BUFFER_EN
            ST_HOLD: begin
                if (BRANCH_TAKEN) begin
                    pc_nxt_s    = BRANCH_TARGET;
                    state_nxt_s = ST_FETCH;
                end else if (!STALL) begin
                    pc_nxt_s    = pc_inc_s;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
`endif
            ST_DRAIN: begin
                if (!IMEM_BUSYWAIT) begin
                    pc_nxt_s    = drain_target_s;
                    state_nxt_s = ST_FETCH;
                end else begin
                    pend_target_nxt_s = drain_target_s;
                    state_nxt_s       = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_FETCH;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_r          <= RESET_PC;
            state_r       <= ST_FETCH;
            pend_target_r <= 32'h0000_0000;
`ifdef IFU_HOLD_BUFFER_EN
            hold_instr_r  <= 32'h0000_0000;
`endif
        end else begin
            pc_r          <= pc_nxt_s;
            state_r       <= state_nxt_s;
            pend_target_r <= pend_target_nxt_s;
`ifdef IFU_HOLD_BUFFER_EN
            hold_instr_r  <= hold_instr_nxt_s;
`endif
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed test-plan steps, then random
// stall/redirect/memory-wait traffic checked against a request-level model of the fetch stream.
module tb_instruction_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDRESS;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic [31:0] OUT_INSTRUCTION;
    logic [31:0] OUT_PC;
    logic        BUSYWAIT;

    int checks = 0;
    int errors = 0;

    // Model: next PC owed to IF/ID, remaining wait of the outstanding read, discard-in-progress
    logic [31:0] exp_pc;
    logic [31:0] drain_addr;
    int          wait_left;
    bit          drain;
    bit          held;

    always #5 CLK = ~CLK;

    instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL),
        .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET),
        .IMEM_READ(IMEM_READ), .IMEM_ADDRESS(IMEM_ADDRESS),
        .IMEM_READDATA(IMEM_READDATA), .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
        .OUT_INSTRUCTION(OUT_INSTRUCTION), .OUT_PC(OUT_PC), .BUSYWAIT(BUSYWAIT)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0200) return 32'h00A0_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n, input int nw);
        for (int i = 0; i < n; i++) begin
            RESET = 1'b1; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'h0000_0000;
            IMEM_BUSYWAIT = 1'b0; IMEM_READDATA = 32'h1234_5678;
            #1;
            chk("rst_imem_read", {31'd0, IMEM_READ}, 32'd0);
            chk("rst_busywait", {31'd0, BUSYWAIT}, 32'd1);
            chk("rst_out_instr", OUT_INSTRUCTION, 32'h0000_0000);
            if (i > 0) chk("rst_out_pc", OUT_PC, RST_PC);
            @(posedge CLK); #1;
        end
        RESET = 1'b0;
        exp_pc = RST_PC; drain = 1'b0; held = 1'b0; wait_left = nw;
    endtask

    // One clock: drive inputs, play the memory, check outputs, then advance the model.
    // nw is the wait count of any new read that starts after this cycle.
    task automatic cycle(input logic st, input logic br, input logic [31:0] tgt, input int nw);
        logic        exp_busy;
        logic        exp_read;
        logic [31:0] exp_addr;
        RESET = 1'b0; STALL = st; BRANCH_TAKEN = br; BRANCH_TARGET = tgt;
        IMEM_BUSYWAIT = (wait_left > 0);
        IMEM_READDATA = IMEM_BUSYWAIT ? 32'hDEAD_BEEF : mem_word(IMEM_ADDRESS);
        exp_busy = br || drain || (wait_left > 0);
`ifdef IFU_HOLD_BUFFER_EN
        exp_read = !held;
`else
        exp_read = 1'b1;
`endif
        exp_addr = drain ? drain_addr : exp_pc;
        #1;
        chk("busywait", {31'd0, BUSYWAIT}, {31'd0, exp_busy});
        chk("imem_read", {31'd0, IMEM_READ}, {31'd0, exp_read});
        chk("imem_addr", IMEM_ADDRESS, exp_addr);
        if (!br && !exp_busy) begin
            chk("out_pc", OUT_PC, exp_pc);
            chk("out_instr", OUT_INSTRUCTION, mem_word(exp_pc));
        end
        @(posedge CLK); #1;
        if (br) begin
            if (drain || wait_left > 0) begin
                if (!drain) drain_addr = exp_pc;
                if (wait_left == 0) begin
                    drain = 1'b0; wait_left = nw;
                end else begin
                    drain = 1'b1; wait_left--;
                end
            end else begin
                wait_left = nw;
            end
            exp_pc = tgt; held = 1'b0;
        end else if (drain) begin
            if (wait_left == 0) begin
                drain = 1'b0; wait_left = nw;
            end else begin
                wait_left--;
            end
        end else if (wait_left > 0) begin
            wait_left--;
        end else if (!st) begin
            exp_pc = exp_pc + 32'd4; wait_left = nw; held = 1'b0;
        end else begin
            held = 1'b1;
        end
    endtask

    initial begin
        RESET = 1'b1; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'h0000_0000;
        IMEM_BUSYWAIT = 1'b0; IMEM_READDATA = 32'h0000_0000;
        exp_pc = RST_PC; drain_addr = 32'h0000_0000; wait_left = 0; drain = 1'b0; held = 1'b0;

        do_reset(2, 0);
        chk("post_reset_pc", OUT_PC, RST_PC);
        repeat (3) cycle(1'b0, 1'b0, 32'h0, 0);
        chk("seq_pc", OUT_PC, 32'h0000_010C);

        // Three wait cycles at 0x200
        cycle(1'b0, 1'b1, 32'h0000_0200, 3);
        repeat (3) cycle(1'b0, 1'b0, 32'h0, 0);
        cycle(1'b0, 1'b0, 32'h0, 0);

        // Stall two cycles on 0x204
        cycle(1'b1, 1'b0, 32'h0, 0);
        cycle(1'b1, 1'b0, 32'h0, 0);
        chk("stall_pc", OUT_PC, 32'h0000_0204);
        cycle(1'b0, 1'b0, 32'h0, 0);
        cycle(1'b0, 1'b0, 32'h0, 0);

        // Redirect while 0x30C still has two wait cycles to go
        cycle(1'b0, 1'b1, 32'h0000_0308, 0);
        cycle(1'b0, 1'b0, 32'h0, 3);
        cycle(1'b0, 1'b0, 32'h0, 0);
        cycle(1'b0, 1'b1, 32'h0000_0400, 0);
        cycle(1'b0, 1'b0, 32'h0, 0);
        cycle(1'b0, 1'b0, 32'h0, 0);
        chk("redir_pc", OUT_PC, 32'h0000_0400);
        cycle(1'b0, 1'b0, 32'h0, 0);

        // Stall and redirect together
        cycle(1'b0, 1'b1, 32'h0000_0500, 0);
        cycle(1'b1, 1'b1, 32'h0000_0600, 0);
        chk("br_stall_pc", OUT_PC, 32'h0000_0600);
        cycle(1'b0, 1'b0, 32'h0, 0);

        // PC wrap
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 0);
        cycle(1'b0, 1'b0, 32'h0, 0);
        cycle(1'b0, 1'b0, 32'h0, 0);
        chk("wrap_pc", OUT_PC, 32'h0000_0000);
        cycle(1'b0, 1'b0, 32'h0, 0);

        // Reset in the middle of a pending read
        cycle(1'b0, 1'b0, 32'h0, 3);
        cycle(1'b0, 1'b0, 32'h0, 0);
        do_reset(1, 0);
        chk("reset_mid_pc", OUT_PC, RST_PC);
        repeat (2) cycle(1'b0, 1'b0, 32'h0, 0);

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  $urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch-side producer for the IF/ID pipeline register. Owns the program counter, runs the read handshake with instruction memory, and presents `OUT_INSTRUCTION`/`OUT_PC` plus a `BUSYWAIT` qualifier. The IF/ID register loads only when `BUSYWAIT` is low. Branch redirects from EX and hazard stalls from downstream are honoured without losing or duplicating instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `CLK` in 1: single clock; all state updates on its rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `STALL` in 1: downstream hazard stall; the presented instruction is not consumed this cycle.
- `BRANCH_TAKEN` in 1: redirect request from EX.
- `BRANCH_TARGET` in 32: redirect address, valid with `BRANCH_TAKEN`.
- `IMEM_READ` out 1: instruction memory read request.
- `IMEM_ADDRESS` out 32: read address (always the current PC).
- `IMEM_READDATA` in 32: read data, valid when `IMEM_READ` is high and `IMEM_BUSYWAIT` is low.
- `IMEM_BUSYWAIT` in 1: memory not ready. The request must stay stable while this is high.
- `OUT_INSTRUCTION` out 32: instruction to the IF/ID register.
- `OUT_PC` out 32: PC of `OUT_INSTRUCTION`.
- `BUSYWAIT` out 1: high means outputs are not a valid instruction and IF/ID must not load.

## Operation
- Registers: `PC`, `STATE` (FETCH, HOLD, DRAIN), `HOLD_INSTR`, `PEND_TARGET`.
- Delivery:
  - An instruction is delivered in any cycle where `BUSYWAIT`=0 and `STALL`=0 and `BRANCH_TAKEN`=0.
  - On delivery, `PC` <= `PC`+4.
- FETCH state:
  - `IMEM_READ`=1, `IMEM_ADDRESS`=`PC`, `OUT_PC`=`PC`.
  - If `IMEM_BUSYWAIT`=1: `BUSYWAIT`=1, stay in FETCH.
  - If `IMEM_BUSYWAIT`=0: `OUT_INSTRUCTION`=`IMEM_READDATA` combinationally, `BUSYWAIT`=0.
    - `STALL`=0: deliver, stay in FETCH.
    - `STALL`=1: `HOLD_INSTR` <= `IMEM_READDATA`, go to HOLD.
- HOLD state:
  - `IMEM_READ`=0, `OUT_INSTRUCTION`=`HOLD_INSTR`, `OUT_PC`=`PC`, `BUSYWAIT`=0.
  - Stay while `STALL`=1. When `STALL`=0, deliver and go to FETCH.
- DRAIN state:
  - `IMEM_READ`=1 with the old `PC` (protocol forbids abandoning a pending read), `BUSYWAIT`=1.
  - When `IMEM_BUSYWAIT`=0: discard the data, `PC` <= `PEND_TARGET`, go to FETCH.
- Redirect (`BRANCH_TAKEN`=1) has priority over everything except `RESET`, and forces `BUSYWAIT`=1 combinationally that cycle:
  - FETCH with `IMEM_BUSYWAIT`=1: `PEND_TARGET` <= `BRANCH_TARGET`, go to DRAIN.
  - FETCH with `IMEM_BUSYWAIT`=0, or HOLD: `PC` <= `BRANCH_TARGET`, go to FETCH; the current instruction is dropped.
  - DRAIN: `PEND_TARGET` <= `BRANCH_TARGET`; the latest redirect wins.
- Arithmetic: `PC`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000. `BRANCH_TARGET` is used unmodified.

## Timing
- Reset cycle (`RESET`=1 at the edge):
  - Registers: `PC`<=`RESET_PC`, `STATE`<=FETCH, `HOLD_INSTR`<=0, `PEND_TARGET`<=0.
  - Outputs while `RESET` is high: `IMEM_READ`=0, `BUSYWAIT`=1, `OUT_INSTRUCTION`=0, `OUT_PC`=`PC`.
- Reset mid-transaction: the pending read is abandoned. Instruction memory shares `RESET` and clears with it.
- Zero-wait memory: one instruction per cycle. `IMEM_READDATA` reaches `OUT_INSTRUCTION` in the same cycle, and IF/ID captures it at the next edge.
- N wait cycles: `BUSYWAIT` is high for N cycles, and the instruction is presented in cycle N+1.
- Redirect with zero-wait memory: exactly one bubble. The target instruction is presented the cycle after `BRANCH_TAKEN`.
- Simultaneous `STALL` and `BRANCH_TAKEN`: the redirect wins and `STALL` is ignored.
- HOLD never issues reads, so `IMEM_ADDRESS` is don't-care there but is still driven as `PC`.

## Configuration
- Macro: `IFU_HOLD_BUFFER_EN`.
- Defined: HOLD state and `HOLD_INSTR` exist as described. A stall never causes a refetch.
- Undefined:
  - No HOLD state and no `HOLD_INSTR`.
  - FETCH with `STALL`=1 leaves `PC` unchanged and keeps `IMEM_READ`=1, so the same address is re-read every cycle until `STALL` drops.
  - Redirect behaviour and delivery semantics are identical. The only visible difference is extra memory reads.

## Test plan
- Reset with `RESET_PC`=32'h100, zero-wait memory -> `OUT_PC` is 0x100, 0x104, 0x108 on consecutive cycles; `BUSYWAIT`=0 from the first post-reset cycle.
- `IMEM_BUSYWAIT` high for 3 cycles at PC 0x200 -> `BUSYWAIT`=1 for 3 cycles, `IMEM_ADDRESS` stable at 0x200, then instruction 0x00A00093 is presented with `OUT_PC`=0x200.
- `STALL` high for 2 cycles while 0x204 is presented -> `OUT_INSTRUCTION`/`OUT_PC` stay fixed; 0x208 follows. With the buffer enabled, there are no reads during the stall.
- `BRANCH_TAKEN`, target 0x400, while a read of 0x30C is pending for 2 more cycles -> `IMEM_ADDRESS` stays 0x30C until ready, 0x30C data is never presented, next valid `OUT_PC`=0x400.
- `BRANCH_TAKEN` and `STALL` in the same cycle at PC 0x500, target 0x600 -> `BUSYWAIT`=1 that cycle; next presented `OUT_PC`=0x600.
- `PC`=32'hFFFF_FFFC delivered -> next `OUT_PC`=0x0. Asserting `RESET` during a pending read -> `PC` returns to `RESET_PC` next cycle, `IMEM_READ`=0 while `RESET` is high.
